// File: rtl/lsu_mem_if_pkg.sv
// Shared definitions for the load/store unit memory interface and the
// downstream load-extension stage: RV32I load/store funct3 encodings,
// FSM state encoding and a funct3 legality helper.
package lsu_mem_if_pkg;

  // Loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Stores
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Stores only support the three signed widths; loads add the unsigned
  // byte/halfword variants.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Word-oriented memory bus between the LSU and the memory system.
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : request, held until mem_ack
//   mem_ack/mem_rdata                         : completion, rdata valid with ack
// master = LSU side, slave = memory side.
interface lsu_mem_if_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_if_align.sv
// lsu_align: combinational byte-lane steering for one load/store request.
//   funct3, we, off : access width/kind and byte offset addr[1:0]
//   wdata           : right-aligned store data
//   be              : byte enables (same mask for loads and stores)
//   lane_wdata      : store data replicated into every byte lane
//   misalign        : misaligned access or illegal funct3
module lsu_align
  import lsu_mem_if_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic        misalign
);

  always_comb begin
    be         = '0;
    lane_wdata = wdata;
    misalign   = 1'b0;
    if (!funct3_legal(we, funct3)) begin
      misalign = 1'b1;
    end else begin
      // funct3[1:0] encodes the width for both signed and unsigned forms
      case (funct3[1:0])
        2'b00: begin
          be         = 4'b0001 << off;
          lane_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          lane_wdata = {2{wdata[15:0]}};
          if (off[0]) misalign = 1'b1;
          else        be = off[1] ? 4'b1100 : 4'b0011;
        end
        2'b10: begin
          if (off != 2'b00) misalign = 1'b1;
          else              be = 4'b1111;
        end
        default: misalign = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit memory interface: accepts one pipeline request at a time,
// issues a single word access on the memory bus and returns the load data
// shifted down to bit 0 (extension is done downstream using resp_funct3).
//   clk, rst_n                    : clock, async active-low reset
//   req_valid/req_ready           : request handshake (ready only when idle)
//   req_we/req_funct3/req_addr/req_wdata : request fields
//   resp_valid/resp_ready         : response handshake, held until accepted
//   resp_rdata/resp_funct3        : load data (0 for stores/errors), funct3
//   resp_misalign/resp_buserr     : misaligned/illegal request, memory timeout
//   mem                           : memory bus (master side)
// TIMEOUT_CYCLES bounds the wait for mem_ack; 0 waits forever.
module lsu_mem_if
  import lsu_mem_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [31:0]  resp_rdata,
  output logic [2:0]   resp_funct3,
  output logic         resp_misalign,
  output logic         resp_buserr,
  lsu_mem_if_if.master mem
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  lsu_state_e       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             cap_we;
  logic [1:0]       cap_off;
  logic [2:0]       cap_funct3;

  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic             misalign_c;
  logic             tmo_hit;

  lsu_align u_align (
    .funct3     (req_funct3),
    .we         (req_we),
    .off        (req_addr[1:0]),
    .wdata      (req_wdata),
    .be         (be_c),
    .lane_wdata (wdata_c),
    .misalign   (misalign_c)
  );

  // Count reaches TMO_LAST on the TIMEOUT_CYCLES-th BUS cycle without ack.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tmo_cnt       <= '0;
      cap_we        <= 1'b0;
      cap_off       <= '0;
      cap_funct3    <= '0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_funct3   <= '0;
      resp_misalign <= 1'b0;
      resp_buserr   <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            cap_we     <= req_we;
            cap_off    <= req_addr[1:0];
            cap_funct3 <= req_funct3;
            if (misalign_c) begin
              state         <= ST_RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_buserr   <= 1'b0;
              resp_rdata    <= '0;
              resp_funct3   <= req_funct3;
            end else begin
              state         <= ST_BUS;
              tmo_cnt       <= '0;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= req_we;
              mem.mem_addr  <= {req_addr[31:2], 2'b00};
              mem.mem_be    <= be_c;
              mem.mem_wdata <= wdata_c;
            end
          end
        end
        ST_BUS: begin
          // ack takes priority over a timeout expiring in the same cycle
          if (mem.mem_ack) begin
            state         <= ST_RESP;
            mem.mem_req   <= 1'b0;
            resp_valid    <= 1'b1;
            resp_misalign <= 1'b0;
            resp_buserr   <= 1'b0;
            resp_funct3   <= cap_funct3;
            resp_rdata    <= cap_we ? '0 : (mem.mem_rdata >> {cap_off, 3'b000});
          end else if (tmo_hit) begin
            state         <= ST_RESP;
            mem.mem_req   <= 1'b0;
            resp_valid    <= 1'b1;
            resp_misalign <= 1'b0;
            resp_buserr   <= 1'b1;
            resp_funct3   <= cap_funct3;
            resp_rdata    <= '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state         <= ST_IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_misalign <= 1'b0;
            resp_buserr   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
module tb_lsu_mem_if;
  import lsu_mem_if_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [2:0]  resp_funct3;
  logic        resp_misalign;
  logic        resp_buserr;

  lsu_mem_if_if bus ();

  lsu_mem_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_funct3   (resp_funct3),
    .resp_misalign (resp_misalign),
    .resp_buserr   (resp_buserr),
    .mem           (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned dly;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rrd;
  } vec_t;

  vec_t vecs[13];

  // Waits (bounded) for req_ready, presents one request for a single cycle.
  // Returns at the negedge of the cycle after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < 20; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
    req_wdata  = 32'h5A5A5A5A;
    req_addr   = 32'hFFFF_FFFF;
  endtask

  task automatic release_resp(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_resp_done"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    issue(v.we, v.f3, v.addr, v.wdata);
    if (v.mis) begin
      chk({t, "_no_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    end else begin
      chk({t, "_mem_req"},  {31'd0, bus.mem_req}, 32'd1);
      chk({t, "_mem_addr"}, bus.mem_addr, {v.addr[31:2], 2'b00});
      chk({t, "_mem_be"},   {28'd0, bus.mem_be}, {28'd0, v.be});
      chk({t, "_mem_we"},   {31'd0, bus.mem_we}, {31'd0, v.we});
      if (v.we) chk({t, "_mem_wdata"}, bus.mem_wdata, v.mwd);
      for (int unsigned d = 0; d < v.dly; d++) begin
        @(negedge clk);
        chk({t, "_mem_req_hold"}, {31'd0, bus.mem_req}, 32'd1);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = v.rdata;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'hDEAD0000;
      chk({t, "_mem_req_drop"}, {31'd0, bus.mem_req}, 32'd0);
    end
    chk({t, "_resp_valid"},  {31'd0, resp_valid}, 32'd1);
    chk({t, "_misalign"},    {31'd0, resp_misalign}, {31'd0, v.mis});
    chk({t, "_buserr"},      {31'd0, resp_buserr}, 32'd0);
    chk({t, "_rdata"},       resp_rdata, v.rrd);
    chk({t, "_funct3"},      {29'd0, resp_funct3}, {29'd0, v.f3});
    release_resp(t);
  endtask

  initial begin
    int cnt;
    int seen;

    //           we    f3      addr          wdata         rdata         dly mis  be       mwd           rrd
    vecs[0]  = '{1'b0, F3_LB,  32'h0000_0103, 32'h1122_3344, 32'hAABB_CCDD, 2, 1'b0, 4'b1000, 32'h0,         32'h0000_00AA};
    vecs[1]  = '{1'b1, F3_SH,  32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[2]  = '{1'b0, F3_LW,  32'h0000_0101, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, F3_LHU, 32'h0000_0102, 32'h0,         32'h89AB_CDEF, 1, 1'b0, 4'b1100, 32'h0,         32'h0000_89AB};
    vecs[5]  = '{1'b0, F3_LH,  32'h0000_0200, 32'h0,         32'h1234_8765, 0, 1'b0, 4'b0011, 32'h0,         32'h1234_8765};
    vecs[6]  = '{1'b0, F3_LW,  32'h0000_0300, 32'h0,         32'hDEAD_BEEF, 3, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, F3_SB,  32'h0000_0401, 32'h0000_00A5, 32'h7777_7777, 1, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[8]  = '{1'b1, F3_SW,  32'h0000_0404, 32'hCAFE_F00D, 32'h0,         0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[9]  = '{1'b1, F3_SH,  32'h0000_0203, 32'h0000_1111, 32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_2222, 32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[11] = '{1'b0, F3_LBU, 32'h0000_0201, 32'h0,         32'h1122_3344, 0, 1'b0, 4'b0010, 32'h0,         32'h0011_2233};
    vecs[12] = '{1'b0, F3_LB,  32'h0000_0000, 32'h0,         32'h0000_007F, 0, 1'b0, 4'b0001, 32'h0,         32'h0000_007F};

    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_funct3    = 3'b000;
    req_addr      = '0;
    req_wdata     = '0;
    resp_ready    = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hDEAD0000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  {31'd0, req_ready}, 32'd0);
    chk("rst_mem_req",    {31'd0, bus.mem_req}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_addr",   bus.mem_addr, 32'd0);
    chk("rst_mem_be",     {28'd0, bus.mem_be}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Stray ack while idle must be ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    bus.mem_ack   = 1'b0;
    chk("idle_ack_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("idle_ack_mem_req",    {31'd0, bus.mem_req}, 32'd0);
    chk("idle_ack_ready",      {31'd0, req_ready}, 32'd1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Timeout: no ack, mem_req held 4 cycles then bus error
    issue(1'b0, F3_LW, 32'h0000_0500, 32'h0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.mem_req) break;
      cnt++;
      @(negedge clk);
    end
    chk("tmo_req_cycles",  cnt, 32'd4);
    chk("tmo_resp_valid",  {31'd0, resp_valid}, 32'd1);
    chk("tmo_buserr",      {31'd0, resp_buserr}, 32'd1);
    chk("tmo_misalign",    {31'd0, resp_misalign}, 32'd0);
    chk("tmo_rdata",       resp_rdata, 32'd0);
    release_resp("tmo");

    // Ack on the 4th BUS cycle beats the expiring timeout
    issue(1'b0, F3_LW, 32'h0000_0600, 32'h0);
    repeat (3) @(negedge clk);
    chk("ack4_mem_req", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5566_7788;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hDEAD0000;
    chk("ack4_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("ack4_buserr",     {31'd0, resp_buserr}, 32'd0);
    chk("ack4_rdata",      resp_rdata, 32'h5566_7788);
    release_resp("ack4");

    // Back-pressure: response held stable for 5 cycles
    issue(1'b0, F3_LBU, 32'h0000_0003, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hF000_0000;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hDEAD0000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata",      resp_rdata, 32'h0000_00F0);
      chk("bp_funct3",     {29'd0, resp_funct3}, {29'd0, F3_LBU});
      chk("bp_req_ready",  {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    release_resp("bp");

    // Reset during BUS: mem_req drops at once, transaction abandoned
    issue(1'b0, F3_LW, 32'h0000_0700, 32'h0);
    chk("rbus_mem_req_pre", {31'd0, bus.mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rbus_mem_req_async", {31'd0, bus.mem_req}, 32'd0);
    chk("rbus_req_ready",     {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid || bus.mem_req) seen++;
    end
    chk("rbus_no_resp", seen, 32'd0);
    run_vec(100, vecs[6]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_mem_if.md
LSU_MEM_IF -- requirements
Module: lsu_mem_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max cycles waiting for mem_ack; 0 disables timeout.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  pipeline memory request valid.
REQ-005 req_ready  out  1  unit idle, request accepted when req_valid&req_ready.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_funct3  in  3  RV32I load/store funct3.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  response valid, held until resp_ready.
REQ-011 resp_ready  in  1  consumer accepts response.
REQ-012 resp_rdata  out  32  load data shifted down to bit 0, not extended; 0 for stores and errors.
REQ-013 resp_funct3  out  3  funct3 of the completed request, for the downstream extender.
REQ-014 resp_misalign  out  1  misaligned or illegal-funct3 request.
REQ-015 resp_buserr  out  1  memory timeout.
REQ-016 mem_req  out  1  memory request, held until mem_ack.
REQ-017 mem_we  out  1  memory write.
REQ-018 mem_addr  out  32  word address, bits [1:0]=0.
REQ-019 mem_be  out  4  byte enables.
REQ-020 mem_wdata  out  32  store data replicated into byte lanes.
REQ-021 mem_ack  in  1  memory completion; mem_rdata valid same cycle.
REQ-022 mem_rdata  in  32  memory read word.

Function
REQ-023 FSM states IDLE, BUS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-024 On acceptance, a legal aligned request SHALL go to BUS with mem_req=1 from the next cycle; mem_addr/mem_we/mem_be/mem_wdata registered and stable while mem_req=1.
REQ-025 Legal funct3: loads 000,001,010,100,101; stores 000,001,010; any other SHALL flag resp_misalign.
REQ-026 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; SHALL skip BUS, go to RESP next cycle with resp_misalign=1, no mem_req.
REQ-027 mem_be: byte = 1<<addr[1:0]; half = 0011 (addr[1]=0) or 1100; word = 1111; loads SHALL drive the same mask.
REQ-028 mem_wdata: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
REQ-029 In BUS, mem_ack=1 SHALL drop mem_req next cycle and enter RESP; resp_rdata = mem_rdata >> (8*addr[1:0]), zero-filled.
REQ-030 Latency: accept cycle N, mem_req at N+1, ack at M >= N+1, resp_valid at M+1.
REQ-031 Timeout counter SHALL clear on BUS entry and increment each BUS cycle without ack; on reaching TIMEOUT_CYCLES, mem_req drops and RESP is entered with resp_buserr=1.
REQ-032 mem_ack in the same cycle as timeout expiry SHALL win: normal response, resp_buserr=0.
REQ-033 mem_ack outside BUS SHALL be ignored.
REQ-034 RESP: outputs stable while resp_valid=1 and resp_ready=0; resp_valid&resp_ready SHALL return to IDLE next cycle (no same-cycle re-accept).
REQ-035 resp_misalign and resp_buserr SHALL never both be 1.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE and all outputs 0 (req_ready=1 after release), including mid-BUS: mem_req drops asynchronously, transaction abandoned, no response.
REQ-037 Counter and captured request registers SHALL reset to 0.

Structure
REQ-038 Shared package: funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW) and FSM state encodings, common with the load-extension stage.
REQ-039 One sub-module, lsu_align: combinational mem_be/mem_wdata/misalign generation from funct3 and addr[1:0].

Verification
REQ-040 LB addr 0x103, mem_rdata 0xAABBCCDD, ack after 2 cycles -> mem_addr 0x100, mem_be 1000, resp_rdata 0x000000AA, resp_funct3 000.
REQ-041 SH addr 0x202 wdata 0x1234ABCD -> mem_we=1, mem_be 1100, mem_wdata 0xABCDABCD, resp_rdata 0.
REQ-042 LW addr 0x101 -> no mem_req, resp_valid next cycle, resp_misalign=1; funct3 011 load same.
REQ-043 TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then resp_buserr=1; repeat with ack on 4th cycle -> resp_buserr=0.
REQ-044 resp_ready held 0 for 5 cycles -> response stable, req_ready=0; then accepted, IDLE next cycle.
REQ-045 rst_n low during BUS -> mem_req 0 same cycle, no resp_valid after release, next request completes normally.
